// File: rtl/rs_latch.sv
// Clocked per-bit set/reset flag register with complementary outputs.
// Conflict (r=s=1) resolution is chosen by PRIORITY at elaboration time.
module rs_latch #(
  parameter int                 WIDTH     = 1,
  parameter int                 PRIORITY  = 0,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic [WIDTH-1:0] conflict
);

  // Out-of-range selections fall back to reset-dominant behaviour.
  localparam int P_EFF = (PRIORITY < 0 || PRIORITY > 3) ? 0 : PRIORITY;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_conf;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_conf_nxt;

  always_comb begin
    w_q_nxt    = r_q;
    w_conf_nxt = '0;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({r[i], s[i]})
          2'b01:   w_q_nxt[i] = 1'b1;
          2'b10:   w_q_nxt[i] = 1'b0;
          2'b11: begin
            w_conf_nxt[i] = 1'b1;
            case (P_EFF)
              1:       w_q_nxt[i] = 1'b1;
              2:       w_q_nxt[i] = r_q[i];
              3:       w_q_nxt[i] = ~r_q[i];
              default: w_q_nxt[i] = 1'b0;
            endcase
          end
          default: w_q_nxt[i] = r_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q    <= RESET_VAL;
      r_conf <= '0;
    end else begin
      r_q    <= w_q_nxt;
      r_conf <= w_conf_nxt;
    end
  end

  // nq comes from the same register so it can never disagree with q.
  assign q        = r_q;
  assign nq       = ~r_q;
  assign conflict = r_conf;

endmodule

// File: tb/tb_rs_latch.sv
// Bench for rs_latch: five instances (PRIORITY 0,1,2,3 and invalid 5)
// driven in parallel and checked against a vector-arithmetic model.
module tb_rs_latch;

  localparam int W = 4;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] r;
  logic [W-1:0] s;
  logic [W-1:0] q_o  [N];
  logic [W-1:0] nq_o [N];
  logic [W-1:0] c_o  [N];
  logic [W-1:0] mq   [N];
  logic [W-1:0] mc   [N];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    rs_latch #(
      .WIDTH    (W),
      .PRIORITY (g == 4 ? 5 : g),
      .RESET_VAL(g == 2 ? 4'hA : 4'h0)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .r       (r),
      .s       (s),
      .en      (en),
      .q       (q_o[g]),
      .nq      (nq_o[g]),
      .conflict(c_o[g])
    );
  end

  function automatic logic [W-1:0] rv(int g);
    return (g == 2) ? 4'hA : 4'h0;
  endfunction

  function automatic int pe(int g);
    return (g > 3) ? 0 : g;
  endfunction

  // Advance one edge and update the model from the inputs seen there.
  task automatic tick();
    logic [W-1:0] both, bq;
    @(posedge clk);
    for (int g = 0; g < N; g++) begin
      if (!rst_n) begin
        mq[g] = rv(g);
        mc[g] = '0;
      end else if (!en) begin
        mc[g] = '0;
      end else begin
        both = r & s;
        case (pe(g))
          0:       bq = '0;
          1:       bq = both;
          2:       bq = mq[g] & both;
          default: bq = ~mq[g] & both;
        endcase
        mq[g] = (mq[g] & ~(r | s)) | (s & ~r) | bq;
        mc[g] = both;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; r = 4'h5; s = 4'hA;
    tick();
    for (int g = 0; g < N; g++) begin
      checks++;
      if (q_o[g] !== mq[g] || nq_o[g] !== ~mq[g] || c_o[g] !== mc[g]) begin
        errors++;
        $display("FAIL reset dut%0d q=%h nq=%h c=%h exp q=%h nq=%h c=%h",
                 g, q_o[g], nq_o[g], c_o[g], mq[g], ~mq[g], mc[g]);
      end
    end
    rst_n = 1'b1; r = 4'hF; s = 4'h0;
    tick();
    for (int g = 0; g < N; g++) begin
      checks++;
      if (q_o[g] !== 4'h0 || nq_o[g] !== 4'hF || c_o[g] !== 4'h0) begin
        errors++;
        $display("FAIL clear dut%0d q=%h nq=%h c=%h exp q=0 nq=f c=0",
                 g, q_o[g], nq_o[g], c_o[g]);
      end
    end
  endtask

  task automatic test_set_clear();
    for (int it = 0; it < 5; it++) begin
      for (int st = 0; st < 6; st++) begin
        case (st)
          0, 1:    begin r = 4'h0; s = 4'h0; end
          2:       begin r = 4'h0; s = 4'hF; end
          3:       begin r = 4'h0; s = 4'h0; end
          default: begin r = 4'hF; s = 4'h0; end
        endcase
        tick();
        for (int g = 0; g < N; g++) begin
          checks++;
          if (q_o[g] !== mq[g] || nq_o[g] !== ~mq[g] ||
              c_o[g] !== mc[g]) begin
            errors++;
            $display("FAIL setclr it%0d st%0d dut%0d q=%h nq=%h c=%h exp q=%h c=%h",
                     it, st, g, q_o[g], nq_o[g], c_o[g], mq[g], mc[g]);
          end
        end
      end
    end
  endtask

  task automatic test_enable();
    en = 1'b0; r = 4'h0; s = 4'hF;
    tick();
    en = 1'b0; r = 'x; s = 'x;
    tick();
    for (int g = 0; g < N; g++) begin
      checks++;
      if (q_o[g] !== 4'h0 || nq_o[g] !== 4'hF || c_o[g] !== 4'h0) begin
        errors++;
        $display("FAIL enable dut%0d q=%h nq=%h c=%h exp q=0 nq=f c=0",
                 g, q_o[g], nq_o[g], c_o[g]);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_conflict();
    for (int st = 0; st < 6; st++) begin
      case (st)
        0:       begin r = 4'hF; s = 4'hF; end
        1:       begin r = 4'h0; s = 4'h0; end
        2:       begin r = 4'h0; s = 4'h6; end
        3, 4:    begin r = 4'hC; s = 4'hF; end
        default: begin r = 4'h0; s = 4'h0; end
      endcase
      tick();
      for (int g = 0; g < N; g++) begin
        checks++;
        if (q_o[g] !== mq[g] || nq_o[g] !== ~mq[g] || c_o[g] !== mc[g]) begin
          errors++;
          $display("FAIL conflict st%0d dut%0d q=%h c=%h exp q=%h c=%h",
                   st, g, q_o[g], c_o[g], mq[g], mc[g]);
        end
      end
    end
  endtask

  task automatic test_reset_override();
    r = 4'h0; s = 4'hF;
    tick();
    rst_n = 1'b0;
    tick();
    for (int g = 0; g < N; g++) begin
      checks++;
      if (q_o[g] !== rv(g) || nq_o[g] !== ~rv(g) || c_o[g] !== 4'h0) begin
        errors++;
        $display("FAIL rst_override dut%0d q=%h nq=%h c=%h exp q=%h",
                 g, q_o[g], nq_o[g], c_o[g], rv(g));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 19) != 0);
      en    = ($urandom_range(0, 3) != 0);
      r     = W'($urandom);
      s     = W'($urandom);
      tick();
      for (int g = 0; g < N; g++) begin
        checks++;
        if (q_o[g] !== mq[g] || nq_o[g] !== ~mq[g] || c_o[g] !== mc[g]) begin
          errors++;
          $display("FAIL random n%0d dut%0d q=%h nq=%h c=%h exp q=%h c=%h",
                   n, g, q_o[g], nq_o[g], c_o[g], mq[g], mc[g]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; r = '0; s = '0;
    #1;
    test_reset();
    test_set_clear();
    test_enable();
    test_conflict();
    test_reset_override();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
